// File: rtl/aclk_alarm_bank_if.sv
// Alarm bank interface: slot load/enable, current time, user controls and display/ring outputs.
// master = key-entry/timekeeping side, slave = the alarm bank.
interface aclk_alarm_bank_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int IDX_W = $clog2(NUM_ALARMS);

  logic             load_new_a;
  logic [IDX_W-1:0] load_idx;
  logic [3:0]       new_alarm_ms_hr;
  logic [3:0]       new_alarm_ls_hr;
  logic [3:0]       new_alarm_ms_min;
  logic [3:0]       new_alarm_ls_min;
  logic             set_en;
  logic             clr_en;

  logic [3:0]       cur_ms_hr;
  logic [3:0]       cur_ls_hr;
  logic [3:0]       cur_ms_min;
  logic [3:0]       cur_ls_min;
  logic             minute_tick;

  logic             stop_alarm;
  logic             snooze;

  logic [IDX_W-1:0] rd_idx;
  logic [3:0]       rd_ms_hr;
  logic [3:0]       rd_ls_hr;
  logic [3:0]       rd_ms_min;
  logic [3:0]       rd_ls_min;

  logic [NUM_ALARMS-1:0] slot_en;
  logic             sound_alarm;
  logic             snoozed;
  logic [IDX_W-1:0] ring_idx;

  modport master (
    output load_new_a, load_idx,
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    output set_en, clr_en,
    output cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, minute_tick,
    output stop_alarm, snooze, rd_idx,
    input  rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min,
    input  slot_en, sound_alarm, snoozed, ring_idx
  );

  modport slave (
    input  load_new_a, load_idx,
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    input  set_en, clr_en,
    input  cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, minute_tick,
    input  stop_alarm, snooze, rd_idx,
    output rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min,
    output slot_en, sound_alarm, snoozed, ring_idx
  );
endinterface

// File: rtl/aclk_alarm_bank.sv
// Multi-slot BCD alarm store with a shared IDLE/RING/SNOOZE ring controller.
// Slot/enable writes and ring state update on the next edge; rd_* is a combinational read mux.
module aclk_alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3
) (
  input logic             clk,
  input logic             rst,
  aclk_alarm_bank_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ALARMS);

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  bcd_time_t             slot_tm [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  bcd_time_t             cur_tm;
  bcd_time_t             new_tm;
  bcd_time_t             rd_tm;
  bcd_time_t             snz_tgt;
  state_t                state;
  logic                  sound_q;
  logic                  snoozed_q;
  logic [IDX_W-1:0]      ring_idx_q;
  logic [5:0]            tmo_cnt;
  logic                  any_match;
  logic [IDX_W-1:0]      match_idx;

  assign cur_tm = {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min};
  assign new_tm = {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr,
                   bus.new_alarm_ms_min, bus.new_alarm_ls_min};

  // BCD time plus SNOOZE_MIN minutes, wrapping through midnight.
  function automatic bcd_time_t add_snooze(input bcd_time_t t);
    logic [6:0] min_bin;
    logic [6:0] hr_bin;
    logic [7:0] min_sum;
    bcd_time_t  r;
    min_bin = 7'(t.ms_min) * 7'd10 + 7'(t.ls_min);
    hr_bin  = 7'(t.ms_hr) * 7'd10 + 7'(t.ls_hr);
    min_sum = {1'b0, min_bin} + 8'(SNOOZE_MIN);
    if (min_sum >= 8'd60) begin
      min_sum = min_sum - 8'd60;
      hr_bin  = hr_bin + 7'd1;
    end
    if (hr_bin >= 7'd24) begin
      hr_bin = hr_bin - 7'd24;
    end
    min_bin  = min_sum[6:0];
    r.ms_min = 4'(min_bin / 7'd10);
    r.ls_min = 4'(min_bin % 7'd10);
    r.ms_hr  = 4'(hr_bin / 7'd10);
    r.ls_hr  = 4'(hr_bin % 7'd10);
    return r;
  endfunction

  // Slot store and enable bits; compare logic below sees the pre-write values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        slot_tm[k] <= '0;
      end
      en_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (bus.load_idx == IDX_W'(k)) begin
          if (bus.load_new_a) begin
            slot_tm[k] <= new_tm;
          end
          if (bus.clr_en) begin
            en_q[k] <= 1'b0;
          end else if (bus.set_en) begin
            en_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Descending scan so the lowest matching slot index wins.
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (bus.minute_tick && en_q[k] && (slot_tm[k] == cur_tm)) begin
        any_match = 1'b1;
        match_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    rd_tm = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (bus.rd_idx == IDX_W'(k)) begin
        rd_tm = slot_tm[k];
      end
    end
  end

  // Ring controller. Priority within RING: stop > snooze > timeout; matches only act from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sound_q    <= 1'b0;
      snoozed_q  <= 1'b0;
      ring_idx_q <= '0;
      snz_tgt    <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_match) begin
            state      <= RING;
            sound_q    <= 1'b1;
            ring_idx_q <= match_idx;
            tmo_cnt    <= '0;
          end
        end
        RING: begin
          if (bus.stop_alarm) begin
            state   <= IDLE;
            sound_q <= 1'b0;
          end else if (bus.snooze) begin
            state     <= SNOOZE;
            sound_q   <= 1'b0;
            snoozed_q <= 1'b1;
            snz_tgt   <= add_snooze(cur_tm);
          end else if (bus.minute_tick) begin
            tmo_cnt <= tmo_cnt + 6'd1;
            if (tmo_cnt == 6'(RING_MIN - 1)) begin
              state   <= IDLE;
              sound_q <= 1'b0;
            end
          end
        end
        SNOOZE: begin
          if (bus.stop_alarm) begin
            state     <= IDLE;
            snoozed_q <= 1'b0;
          end else if (bus.minute_tick && (cur_tm == snz_tgt)) begin
            state     <= RING;
            sound_q   <= 1'b1;
            snoozed_q <= 1'b0;
            tmo_cnt   <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          sound_q   <= 1'b0;
          snoozed_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_ms_hr    = rd_tm.ms_hr;
  assign bus.rd_ls_hr    = rd_tm.ls_hr;
  assign bus.rd_ms_min   = rd_tm.ms_min;
  assign bus.rd_ls_min   = rd_tm.ls_min;
  assign bus.slot_en     = en_q;
  assign bus.sound_alarm = sound_q;
  assign bus.snoozed     = snoozed_q;
  assign bus.ring_idx    = ring_idx_q;

endmodule

// File: tb/tb_aclk_alarm_bank.sv
// Directed, table-driven bench for aclk_alarm_bank (4 slots, 5 min snooze, 3 min ring timeout).
module tb_aclk_alarm_bank;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  aclk_alarm_bank_if #(.NUM_ALARMS(4)) bus ();

  aclk_alarm_bank #(
    .NUM_ALARMS(4),
    .SNOOZE_MIN(5),
    .RING_MIN  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [1:0]  idx;
    logic [15:0] nw;
    logic        se;
    logic        ce;
    logic [15:0] cur;
    logic        tick;
    logic        stop;
    logic        snz;
    logic [1:0]  rd;
    logic [15:0] e_rd;
    logic [3:0]  e_en;
    logic        e_snd;
    logic        e_snzd;
    logic [1:0]  e_ri;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic load, input logic [1:0] idx, input logic [15:0] nw,
                             input logic se, input logic ce, input logic [15:0] cur,
                             input logic tick, input logic stop, input logic snz,
                             input logic [1:0] rd, input logic [15:0] e_rd, input logic [3:0] e_en,
                             input logic e_snd, input logic e_snzd, input logic [1:0] e_ri);
    vec_t r;
    r.load = load; r.idx = idx; r.nw = nw; r.se = se; r.ce = ce;
    r.cur = cur; r.tick = tick; r.stop = stop; r.snz = snz; r.rd = rd;
    r.e_rd = e_rd; r.e_en = e_en; r.e_snd = e_snd; r.e_snzd = e_snzd; r.e_ri = e_ri;
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", nm, i, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.load_new_a       = t.load;
    bus.load_idx         = t.idx;
    {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = t.nw;
    bus.set_en           = t.se;
    bus.clr_en           = t.ce;
    {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min} = t.cur;
    bus.minute_tick      = t.tick;
    bus.stop_alarm       = t.stop;
    bus.snooze           = t.snz;
    bus.rd_idx           = t.rd;
  endtask

  task automatic check_outs(input vec_t t, input int i);
    chk("rd_time",     i, {bus.rd_ms_hr, bus.rd_ls_hr, bus.rd_ms_min, bus.rd_ls_min}, t.e_rd);
    chk("slot_en",     i, 16'(bus.slot_en), 16'(t.e_en));
    chk("sound_alarm", i, 16'(bus.sound_alarm), 16'(t.e_snd));
    chk("snoozed",     i, 16'(bus.snoozed), 16'(t.e_snzd));
    chk("ring_idx",    i, 16'(bus.ring_idx), 16'(t.e_ri));
  endtask

  // Drive one cycle of inputs, then check state after the edge.
  task automatic step(input vec_t t, input int i);
    drive(t);
    @(posedge clk);
    #1;
    check_outs(t, i);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(v(0,0,16'h0000,0,0,16'h0000,0,0,0,0,16'h0000,4'b0000,0,0,0));

    //        ld idx new      se ce cur      tk sp sz rd  e_rd     e_en     snd snzd ri
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0000,0,0,0,0,16'h0000,4'b0000,0,0,0)); // 0 reset state
    vecs.push_back(v(1,2,16'h0730,1,0,16'h0000,0,0,0,2,16'h0730,4'b0100,0,0,0)); // 1 load+enable slot2
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0730,1,0,0,2,16'h0730,4'b0100,1,0,2)); // 2 match -> ring
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0730,0,1,0,2,16'h0730,4'b0100,0,0,2)); // 3 stop
    vecs.push_back(v(1,1,16'h0600,1,0,16'h0730,0,0,0,1,16'h0600,4'b0110,0,0,2)); // 4 slot1 06:00
    vecs.push_back(v(1,3,16'h0600,1,0,16'h0730,0,0,0,3,16'h0600,4'b1110,0,0,2)); // 5 slot3 06:00
    vecs.push_back(v(1,0,16'h0600,0,0,16'h0730,0,0,0,0,16'h0600,4'b1110,0,0,2)); // 6 slot0 06:00 disabled
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,0,16'h0600,4'b1110,1,0,1)); // 7 lowest enabled = 1
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,0,1,0,0,16'h0600,4'b1110,0,0,1)); // 8 stop
    vecs.push_back(v(0,1,16'h0000,1,1,16'h0600,0,0,0,1,16'h0600,4'b1100,0,0,1)); // 9 clr wins over set
    vecs.push_back(v(0,3,16'h0000,0,1,16'h0600,0,0,0,3,16'h0600,4'b0100,0,0,1)); // 10 clear slot3
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,0,16'h0600,4'b0100,0,0,1)); // 11 disabled slots silent
    vecs.push_back(v(0,0,16'h0000,1,0,16'h0600,0,0,0,0,16'h0600,4'b0101,0,0,1)); // 12 enable slot0
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,0,16'h0600,4'b0101,1,0,0)); // 13 ring slot0
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0601,1,0,0,0,16'h0600,4'b0101,1,0,0)); // 14 timeout tick 1
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0602,1,0,0,0,16'h0600,4'b0101,1,0,0)); // 15 timeout tick 2
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0603,1,0,0,0,16'h0600,4'b0101,0,0,0)); // 16 timeout tick 3 -> idle
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,0,16'h0600,4'b0101,1,0,0)); // 17 ring again
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,0,1,1,0,16'h0600,4'b0101,0,0,0)); // 18 stop beats snooze
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,0,16'h0600,4'b0101,1,0,0)); // 19 ring
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,1,0,0,16'h0600,4'b0101,0,0,0)); // 20 stop+matching tick
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,0,0,0,0,16'h0600,4'b0101,0,0,0)); // 21 stays idle
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,0,16'h0600,4'b0101,1,0,0)); // 22 re-arm from idle
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,0,1,0,0,16'h0600,4'b0101,0,0,0)); // 23 stop
    vecs.push_back(v(1,3,16'h2358,1,0,16'h0600,0,0,0,3,16'h2358,4'b1101,0,0,0)); // 24 slot3 23:58
    vecs.push_back(v(0,0,16'h0000,0,0,16'h2358,1,0,0,3,16'h2358,4'b1101,1,0,3)); // 25 ring slot3
    vecs.push_back(v(0,0,16'h0000,0,0,16'h2358,0,0,1,3,16'h2358,4'b1101,0,1,3)); // 26 snooze -> 00:03
    vecs.push_back(v(0,0,16'h0000,0,0,16'h2359,1,0,0,3,16'h2358,4'b1101,0,1,3)); // 27
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0600,1,0,0,3,16'h2358,4'b1101,0,1,3)); // 28 slot match ignored
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0000,1,0,0,3,16'h2358,4'b1101,0,1,3)); // 29
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0001,1,0,0,3,16'h2358,4'b1101,0,1,3)); // 30
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0002,1,0,0,3,16'h2358,4'b1101,0,1,3)); // 31
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0003,1,0,0,3,16'h2358,4'b1101,1,0,3)); // 32 snooze expiry
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0003,0,0,1,3,16'h2358,4'b1101,0,1,3)); // 33 snooze again
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0004,0,1,0,3,16'h2358,4'b1101,0,0,3)); // 34 stop from snooze
    vecs.push_back(v(1,2,16'h0900,0,0,16'h0730,1,0,0,2,16'h0900,4'b1101,1,0,2)); // 35 old value matches
    vecs.push_back(v(0,0,16'h0000,0,0,16'h0730,0,1,0,2,16'h0900,4'b1101,0,0,2)); // 36 stop

    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i], i);

    // Hour-digit carry in snooze: 09:57 + 5 = 10:02.
    step(v(1,1,16'h0957,1,0,16'h0900,0,0,0,1,16'h0957,4'b1111,0,0,2), 100);
    step(v(0,0,16'h0000,0,0,16'h0957,1,0,0,1,16'h0957,4'b1111,1,0,1), 101);
    step(v(0,0,16'h0000,0,0,16'h0957,0,0,1,1,16'h0957,4'b1111,0,1,1), 102);
    step(v(0,0,16'h0000,0,0,16'h1001,1,0,0,1,16'h0957,4'b1111,0,1,1), 103);
    step(v(0,0,16'h0000,0,0,16'h1002,1,0,0,1,16'h0957,4'b1111,1,0,1), 104);
    step(v(0,0,16'h0000,0,0,16'h1002,0,0,1,1,16'h0957,4'b1111,0,1,1), 105);

    // Asynchronous reset mid-snooze: outputs clear before the next edge.
    drive(v(0,0,16'h0000,0,0,16'h1003,0,0,0,2,16'h0000,4'b0000,0,0,0));
    #2;
    rst = 1'b1;
    #1;
    check_outs(v(0,0,16'h0000,0,0,16'h0000,0,0,0,2,16'h0000,4'b0000,0,0,0), 200);
    #3;
    rst = 1'b0;
    // With all slots disabled a tick at an old alarm time stays silent.
    step(v(0,0,16'h0000,0,0,16'h0900,1,0,0,2,16'h0000,4'b0000,0,0,0), 201);
    step(v(0,0,16'h0000,0,0,16'h0000,1,0,0,0,16'h0000,4'b0000,0,0,0), 202);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
